// File: rtl/ex_pkg.sv
// Shared ID/EX encodings: operand source selects, ALU select codes and the latched ID/EX record.
package ex_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int ALU_OP_W = 4;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    localparam logic SRC_B_RS2 = 1'b0;
    localparam logic SRC_B_IMM = 1'b1;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0]   pc;
        logic [DATA_W-1:0]   rs1_data;
        logic [DATA_W-1:0]   rs2_data;
        logic [DATA_W-1:0]   imm;
        logic [REG_AW-1:0]   rs1_addr;
        logic [REG_AW-1:0]   rs2_addr;
        logic [REG_AW-1:0]   rd;
        logic [1:0]          src_a_sel;
        logic                src_b_sel;
        logic [ALU_OP_W-1:0] alu_op;
        logic                reg_write;
        logic                is_load;
    } id_ex_t;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decode-to-EX instruction offer: decode drives valid and the decoded fields, the stage answers ready.
interface ex_operand_stage_if #(
    parameter int WIDTH   = 32,
    parameter int RADDR_W = 5,
    parameter int OP_W    = 4
);
    logic               id_valid;
    logic               id_ready;
    logic [WIDTH-1:0]   id_pc;
    logic [WIDTH-1:0]   id_rs1_data;
    logic [WIDTH-1:0]   id_rs2_data;
    logic [WIDTH-1:0]   id_imm;
    logic [RADDR_W-1:0] id_rs1_addr;
    logic [RADDR_W-1:0] id_rs2_addr;
    logic [RADDR_W-1:0] id_rd_addr;
    logic               id_use_rs1;
    logic               id_use_rs2;
    logic [1:0]         id_src_a_sel;
    logic               id_src_b_sel;
    logic [OP_W-1:0]    id_alu_op;
    logic               id_reg_write;
    logic               id_is_load;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_use_rs1, id_use_rs2,
               id_src_a_sel, id_src_b_sel, id_alu_op, id_reg_write, id_is_load,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_use_rs1, id_use_rs2,
               id_src_a_sel, id_src_b_sel, id_alu_op, id_reg_write, id_is_load,
        output id_ready
    );
endinterface

// File: rtl/fwd_mux.sv
// Forward select for one source operand: x0 -> 0, then MEM, then WB, else register data.
// Latency: combinational. Backpressure: none.
module fwd_mux
    import ex_pkg::*;
#(
    parameter int WIDTH   = DATA_W,
    parameter int RADDR_W = REG_AW
) (
    input  logic [RADDR_W-1:0] src_idx,
    input  logic [WIDTH-1:0]   reg_data,
    input  logic               mem_fwd_valid,
    input  logic [RADDR_W-1:0] mem_fwd_rd,
    input  logic [WIDTH-1:0]   mem_fwd_data,
    input  logic               wb_fwd_valid,
    input  logic [RADDR_W-1:0] wb_fwd_rd,
    input  logic [WIDTH-1:0]   wb_fwd_data,
    output logic [WIDTH-1:0]   fwd_data
);

    always_comb begin
        fwd_data = reg_data;
        if (src_idx == '0) begin
            fwd_data = '0;
        end else if (mem_fwd_valid && (mem_fwd_rd == src_idx)) begin
            fwd_data = mem_fwd_data;
        end else if (wb_fwd_valid && (wb_fwd_rd == src_idx)) begin
            fwd_data = wb_fwd_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with MEM/WB forwarding, load-use bubble and flush; one cycle accept -> ex_valid.
// Backpressure: ex_ready low holds EX and drops id_ready; a load-use hazard or flush also drops id_ready.
module ex_operand_stage
    import ex_pkg::*;
#(
    parameter int WIDTH   = DATA_W,
    parameter int RADDR_W = REG_AW,
    parameter int OP_W    = ALU_OP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    ex_operand_stage_if.slave  id_bus,
    input  logic               flush,
    input  logic               mem_fwd_valid,
    input  logic [RADDR_W-1:0] mem_fwd_rd,
    input  logic [WIDTH-1:0]   mem_fwd_data,
    input  logic               wb_fwd_valid,
    input  logic [RADDR_W-1:0] wb_fwd_rd,
    input  logic [WIDTH-1:0]   wb_fwd_data,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [WIDTH-1:0]   alu_i0,
    output logic [WIDTH-1:0]   alu_i1,
    output logic [OP_W-1:0]    alu_s,
    output logic [WIDTH-1:0]   ex_pc,
    output logic [WIDTH-1:0]   ex_store_data,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_reg_write,
    output logic               ex_is_load
);

    id_ex_t           ex_q;
    id_ex_t           id_fields;
    logic             ex_valid_q;
    logic             hazard;
    logic             capture;
    logic [WIDTH-1:0] rs1_fwd;
    logic [WIDTH-1:0] rs2_fwd;

    // A load in EX has no data until WB; a dependent offer waits one cycle.
    assign hazard = ex_valid_q && ex_q.is_load && (ex_q.rd != '0) &&
                    ((id_bus.id_use_rs1 && (id_bus.id_rs1_addr == ex_q.rd)) ||
                     (id_bus.id_use_rs2 && (id_bus.id_rs2_addr == ex_q.rd)));

    assign id_bus.id_ready = (!ex_valid_q || ex_ready) && !hazard && !flush;
    assign capture         = id_bus.id_valid && id_bus.id_ready;

    always_comb begin
        id_fields           = '0;
        id_fields.pc        = id_bus.id_pc;
        id_fields.rs1_data  = id_bus.id_rs1_data;
        id_fields.rs2_data  = id_bus.id_rs2_data;
        id_fields.imm       = id_bus.id_imm;
        id_fields.rs1_addr  = id_bus.id_rs1_addr;
        id_fields.rs2_addr  = id_bus.id_rs2_addr;
        id_fields.rd        = id_bus.id_rd_addr;
        id_fields.src_a_sel = id_bus.id_src_a_sel;
        id_fields.src_b_sel = id_bus.id_src_b_sel;
        id_fields.alu_op    = id_bus.id_alu_op;
        id_fields.reg_write = id_bus.id_reg_write;
        id_fields.is_load   = id_bus.id_is_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (capture) begin
            ex_q       <= id_fields;
            ex_valid_q <= 1'b1;
        end else if (ex_ready || !ex_valid_q) begin
            ex_valid_q <= 1'b0;
        end
    end

    fwd_mux #(.WIDTH(WIDTH), .RADDR_W(RADDR_W)) u_fwd_rs1 (
        .src_idx       (ex_q.rs1_addr),
        .reg_data      (ex_q.rs1_data),
        .mem_fwd_valid (mem_fwd_valid),
        .mem_fwd_rd    (mem_fwd_rd),
        .mem_fwd_data  (mem_fwd_data),
        .wb_fwd_valid  (wb_fwd_valid),
        .wb_fwd_rd     (wb_fwd_rd),
        .wb_fwd_data   (wb_fwd_data),
        .fwd_data      (rs1_fwd)
    );

    fwd_mux #(.WIDTH(WIDTH), .RADDR_W(RADDR_W)) u_fwd_rs2 (
        .src_idx       (ex_q.rs2_addr),
        .reg_data      (ex_q.rs2_data),
        .mem_fwd_valid (mem_fwd_valid),
        .mem_fwd_rd    (mem_fwd_rd),
        .mem_fwd_data  (mem_fwd_data),
        .wb_fwd_valid  (wb_fwd_valid),
        .wb_fwd_rd     (wb_fwd_rd),
        .wb_fwd_data   (wb_fwd_data),
        .fwd_data      (rs2_fwd)
    );

    // The reserved A-select code reads as zero, same as SRC_A_ZERO.
    always_comb begin
        case (ex_q.src_a_sel)
            SRC_A_RS1: alu_i0 = rs1_fwd;
            SRC_A_PC:  alu_i0 = ex_q.pc;
            default:   alu_i0 = '0;
        endcase
    end

    assign alu_i1        = (ex_q.src_b_sel == SRC_B_IMM) ? ex_q.imm : rs2_fwd;
    assign alu_s         = ex_q.alu_op;
    assign ex_valid      = ex_valid_q;
    assign ex_pc         = ex_q.pc;
    assign ex_store_data = rs2_fwd;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_valid_q && ex_q.reg_write;
    assign ex_is_load    = ex_valid_q && ex_q.is_load;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: pass-through, operand select, forwarding, load-use,
// back-pressure, flush and asynchronous reset, each with hand-computed expectations.
module tb_ex_operand_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush;
    logic        mem_fwd_valid;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_valid;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] alu_i0;
    logic [31:0] alu_i1;
    logic [3:0]  alu_s;
    logic [31:0] ex_pc;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_is_load;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_operand_stage_if #(.WIDTH(32), .RADDR_W(5), .OP_W(4)) id_bus ();

    ex_operand_stage #(.WIDTH(32), .RADDR_W(5), .OP_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_bus        (id_bus),
        .flush         (flush),
        .mem_fwd_valid (mem_fwd_valid),
        .mem_fwd_rd    (mem_fwd_rd),
        .mem_fwd_data  (mem_fwd_data),
        .wb_fwd_valid  (wb_fwd_valid),
        .wb_fwd_rd     (wb_fwd_rd),
        .wb_fwd_data   (wb_fwd_data),
        .ex_ready      (ex_ready),
        .ex_valid      (ex_valid),
        .alu_i0        (alu_i0),
        .alu_i1        (alu_i1),
        .alu_s         (alu_s),
        .ex_pc         (ex_pc),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_is_load    (ex_is_load)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_bus.id_valid     = 1'b0;
        id_bus.id_pc        = '0;
        id_bus.id_rs1_data  = '0;
        id_bus.id_rs2_data  = '0;
        id_bus.id_imm       = '0;
        id_bus.id_rs1_addr  = '0;
        id_bus.id_rs2_addr  = '0;
        id_bus.id_rd_addr   = '0;
        id_bus.id_use_rs1   = 1'b0;
        id_bus.id_use_rs2   = 1'b0;
        id_bus.id_src_a_sel = '0;
        id_bus.id_src_b_sel = 1'b0;
        id_bus.id_alu_op    = '0;
        id_bus.id_reg_write = 1'b0;
        id_bus.id_is_load   = 1'b0;
    endtask

    task automatic fwd_off();
        mem_fwd_valid = 1'b0;
        mem_fwd_rd    = '0;
        mem_fwd_data  = '0;
        wb_fwd_valid  = 1'b0;
        wb_fwd_rd     = '0;
        wb_fwd_data   = '0;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] rs1d, input logic [31:0] rs2d,
                         input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic [1:0] sa, input logic sb, input logic [3:0] op,
                         input logic rw, input logic ld);
        id_bus.id_valid     = 1'b1;
        id_bus.id_pc        = pc;
        id_bus.id_rs1_data  = rs1d;
        id_bus.id_rs2_data  = rs2d;
        id_bus.id_imm       = imm;
        id_bus.id_rs1_addr  = rs1;
        id_bus.id_rs2_addr  = rs2;
        id_bus.id_rd_addr   = rd;
        id_bus.id_use_rs1   = u1;
        id_bus.id_use_rs2   = u2;
        id_bus.id_src_a_sel = sa;
        id_bus.id_src_b_sel = sb;
        id_bus.id_alu_op    = op;
        id_bus.id_reg_write = rw;
        id_bus.id_is_load   = ld;
    endtask

    task automatic test_reset();
        idle();
        fwd_off();
        flush    = 1'b0;
        ex_ready = 1'b1;
        rst_n    = 1'b0;
        #12;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %0h want 0", ex_valid); end
        checks++; if (alu_i0 !== 32'h0) begin errors++; $display("FAIL reset_alu_i0 got %0h want 0", alu_i0); end
        checks++; if (alu_i1 !== 32'h0) begin errors++; $display("FAIL reset_alu_i1 got %0h want 0", alu_i1); end
        checks++; if (alu_s !== 4'h0) begin errors++; $display("FAIL reset_alu_s got %0h want 0", alu_s); end
        checks++; if (ex_pc !== 32'h0) begin errors++; $display("FAIL reset_ex_pc got %0h want 0", ex_pc); end
        checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write got %0h want 0", ex_reg_write); end
        checks++; if (id_bus.id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready got %0h want 1", id_bus.id_ready); end
        #6;
        rst_n = 1'b1;
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got %0h want 0", ex_valid); end
    endtask

    task automatic test_pass_through();
        ex_ready = 1'b1;
        offer(32'h100, 32'h10, 32'h20, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, SRC_A_RS1, SRC_B_RS2, ALU_SUB, 1'b1, 1'b0);
        #1;
        checks++; if (id_bus.id_ready !== 1'b1) begin errors++; $display("FAIL pass_id_ready got %0h want 1", id_bus.id_ready); end
        step();
        idle();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL pass_ex_valid got %0h want 1", ex_valid); end
        checks++; if (alu_i0 !== 32'h10) begin errors++; $display("FAIL pass_alu_i0 got %0h want 10", alu_i0); end
        checks++; if (alu_i1 !== 32'h20) begin errors++; $display("FAIL pass_alu_i1 got %0h want 20", alu_i1); end
        checks++; if (alu_s !== 4'h1) begin errors++; $display("FAIL pass_alu_s got %0h want 1", alu_s); end
        checks++; if (ex_pc !== 32'h100) begin errors++; $display("FAIL pass_ex_pc got %0h want 100", ex_pc); end
        checks++; if (ex_rd !== 5'd3) begin errors++; $display("FAIL pass_ex_rd got %0h want 3", ex_rd); end
        checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL pass_reg_write got %0h want 1", ex_reg_write); end
        checks++; if (ex_store_data !== 32'h20) begin errors++; $display("FAIL pass_store_data got %0h want 20", ex_store_data); end
    endtask

    task automatic test_operand_select();
        offer(32'h104, 32'h10, 32'h20, 32'h7, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, SRC_A_PC, SRC_B_IMM, ALU_ADD, 1'b1, 1'b0);
        step();
        idle();
        checks++; if (alu_i0 !== 32'h104) begin errors++; $display("FAIL sel_pc_alu_i0 got %0h want 104", alu_i0); end
        checks++; if (alu_i1 !== 32'h7) begin errors++; $display("FAIL sel_imm_alu_i1 got %0h want 7", alu_i1); end
        checks++; if (ex_store_data !== 32'h20) begin errors++; $display("FAIL sel_store_data got %0h want 20", ex_store_data); end
        offer(32'h108, 32'h10, 32'h20, 32'h7, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 2'd3, SRC_B_RS2, ALU_ADD, 1'b1, 1'b0);
        step();
        idle();
        checks++; if (alu_i0 !== 32'h0) begin errors++; $display("FAIL sel_reserved_alu_i0 got %0h want 0", alu_i0); end
        checks++; if (alu_i1 !== 32'h20) begin errors++; $display("FAIL sel_rs2_alu_i1 got %0h want 20", alu_i1); end
    endtask

    task automatic test_forward_priority();
        offer(32'h180, 32'h1, 32'h2, 32'h9, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, SRC_A_RS1, SRC_B_IMM, ALU_AND, 1'b1, 1'b0);
        step();
        idle();
        ex_ready      = 1'b0;
        mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'hAA;
        wb_fwd_valid  = 1'b1; wb_fwd_rd  = 5'd5; wb_fwd_data  = 32'hBB;
        #1;
        checks++; if (alu_i0 !== 32'hAA) begin errors++; $display("FAIL fwd_mem_over_wb got %0h want aa", alu_i0); end
        mem_fwd_valid = 1'b0;
        #1;
        checks++; if (alu_i0 !== 32'hBB) begin errors++; $display("FAIL fwd_wb got %0h want bb", alu_i0); end
        wb_fwd_valid = 1'b0;
        #1;
        checks++; if (alu_i0 !== 32'h1) begin errors++; $display("FAIL fwd_none got %0h want 1", alu_i0); end
        mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd6; mem_fwd_data = 32'hCC;
        #1;
        checks++; if (ex_store_data !== 32'hCC) begin errors++; $display("FAIL fwd_store_data got %0h want cc", ex_store_data); end
        checks++; if (alu_i1 !== 32'h9) begin errors++; $display("FAIL fwd_imm_unaffected got %0h want 9", alu_i1); end
        fwd_off();
        ex_ready = 1'b1;
        offer(32'h184, 32'h55, 32'h2, 32'h0, 5'd0, 5'd6, 5'd7, 1'b1, 1'b1, SRC_A_RS1, SRC_B_RS2, ALU_AND, 1'b1, 1'b0);
        step();
        idle();
        mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hAA;
        wb_fwd_valid  = 1'b1; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'hBB;
        #1;
        checks++; if (alu_i0 !== 32'h0) begin errors++; $display("FAIL fwd_x0 got %0h want 0", alu_i0); end
        fwd_off();
    endtask

    task automatic test_load_use();
        ex_ready = 1'b1;
        offer(32'h200, 32'h1000, 32'h0, 32'h4, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, SRC_A_RS1, SRC_B_IMM, ALU_ADD, 1'b1, 1'b1);
        step();
        offer(32'h204, 32'h5, 32'hDEAD, 32'h0, 5'd4, 5'd3, 5'd8, 1'b1, 1'b1, SRC_A_RS1, SRC_B_RS2, ALU_ADD, 1'b1, 1'b0);
        #1;
        checks++; if (ex_is_load !== 1'b1) begin errors++; $display("FAIL lu_load_in_ex got %0h want 1", ex_is_load); end
        checks++; if (id_bus.id_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_ready got %0h want 0", id_bus.id_ready); end
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble_valid got %0h want 0", ex_valid); end
        checks++; if (ex_is_load !== 1'b0) begin errors++; $display("FAIL lu_bubble_is_load got %0h want 0", ex_is_load); end
        #1;
        checks++; if (id_bus.id_ready !== 1'b1) begin errors++; $display("FAIL lu_ready_after_bubble got %0h want 1", id_bus.id_ready); end
        step();
        idle();
        checks++; if (ex_pc !== 32'h204 || ex_valid !== 1'b1) begin errors++; $display("FAIL lu_dep_enters got pc %0h valid %0h want 204 1", ex_pc, ex_valid); end
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd3; wb_fwd_data = 32'h1234;
        #1;
        checks++; if (alu_i1 !== 32'h1234) begin errors++; $display("FAIL lu_wb_forward got %0h want 1234", alu_i1); end
        checks++; if (alu_i0 !== 32'h5) begin errors++; $display("FAIL lu_rs1_reg got %0h want 5", alu_i0); end
        fwd_off();
        // A load to x0 never creates a hazard.
        offer(32'h210, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, SRC_A_RS1, SRC_B_IMM, ALU_ADD, 1'b1, 1'b1);
        step();
        offer(32'h214, 32'h0, 32'h0, 32'h0, 5'd4, 5'd0, 5'd8, 1'b1, 1'b1, SRC_A_RS1, SRC_B_RS2, ALU_ADD, 1'b1, 1'b0);
        #1;
        checks++; if (id_bus.id_ready !== 1'b1) begin errors++; $display("FAIL lu_x0_no_hazard got %0h want 1", id_bus.id_ready); end
        step();
        offer(32'h218, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, SRC_A_RS1, SRC_B_IMM, ALU_ADD, 1'b1, 1'b1);
        step();
        offer(32'h21C, 32'h0, 32'h0, 32'h0, 5'd4, 5'd3, 5'd8, 1'b1, 1'b0, SRC_A_RS1, SRC_B_IMM, ALU_ADD, 1'b1, 1'b0);
        #1;
        checks++; if (id_bus.id_ready !== 1'b1) begin errors++; $display("FAIL lu_unused_rs2_no_hazard got %0h want 1", id_bus.id_ready); end
        step();
        idle();
    endtask

    task automatic test_back_pressure();
        ex_ready = 1'b1;
        offer(32'h300, 32'h11, 32'h22, 32'h0, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, SRC_A_RS1, SRC_B_RS2, ALU_XOR, 1'b1, 1'b0);
        step();
        ex_ready = 1'b0;
        offer(32'h304, 32'h33, 32'h44, 32'h0, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, SRC_A_RS1, SRC_B_RS2, ALU_OR, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (id_bus.id_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cycle %0d got %0h want 0", i, id_bus.id_ready); end
            step();
            checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h300 || alu_i0 !== 32'h11 || alu_i1 !== 32'h22 || alu_s !== 4'h4) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid %0h pc %0h i0 %0h i1 %0h s %0h want 1 300 11 22 4", i, ex_valid, ex_pc, alu_i0, alu_i1, alu_s);
            end
        end
        ex_ready = 1'b1;
        #1;
        checks++; if (id_bus.id_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0h want 1", id_bus.id_ready); end
        step();
        idle();
        checks++; if (ex_pc !== 32'h304 || alu_i0 !== 32'h33) begin errors++; $display("FAIL bp_next_capture got pc %0h i0 %0h want 304 33", ex_pc, alu_i0); end
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        offer(32'h400, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, SRC_A_RS1, SRC_B_RS2, ALU_ADD, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        checks++; if (id_bus.id_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0h want 0", id_bus.id_ready); end
        step();
        flush = 1'b0;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h want 0", ex_valid); end
        checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL flush_reg_write got %0h want 0", ex_reg_write); end
        checks++; if (ex_pc !== 32'h304) begin errors++; $display("FAIL flush_not_accepted got pc %0h want 304", ex_pc); end
        step();
        idle();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h400) begin errors++; $display("FAIL flush_reoffer got valid %0h pc %0h want 1 400", ex_valid, ex_pc); end
        ex_ready = 1'b1;
        offer(32'h410, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, SRC_A_RS1, SRC_B_IMM, ALU_ADD, 1'b1, 1'b1);
        step();
        offer(32'h414, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0, 5'd8, 1'b1, 1'b0, SRC_A_RS1, SRC_B_IMM, ALU_ADD, 1'b1, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        checks++; if (ex_valid !== 1'b0 || ex_is_load !== 1'b0 || ex_pc !== 32'h410) begin
            errors++;
            $display("FAIL flush_with_hazard got valid %0h load %0h pc %0h want 0 0 410", ex_valid, ex_is_load, ex_pc);
        end
    endtask

    task automatic test_async_reset();
        ex_ready = 1'b1;
        offer(32'h500, 32'h77, 32'h88, 32'h99, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1, SRC_A_RS1, SRC_B_IMM, ALU_SRA, 1'b1, 1'b1);
        step();
        idle();
        ex_ready = 1'b0;
        step();
        checks++; if (ex_valid !== 1'b1 || alu_i0 !== 32'h77) begin errors++; $display("FAIL arst_pre_held got valid %0h i0 %0h want 1 77", ex_valid, alu_i0); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0h want 0", ex_valid); end
        checks++; if (alu_i0 !== 32'h0 || alu_i1 !== 32'h0 || alu_s !== 4'h0) begin
            errors++;
            $display("FAIL arst_alu got i0 %0h i1 %0h s %0h want 0 0 0", alu_i0, alu_i1, alu_s);
        end
        checks++; if (ex_pc !== 32'h0 || ex_store_data !== 32'h0 || ex_rd !== 5'd0) begin
            errors++;
            $display("FAIL arst_fields got pc %0h sd %0h rd %0h want 0 0 0", ex_pc, ex_store_data, ex_rd);
        end
        checks++; if (ex_reg_write !== 1'b0 || ex_is_load !== 1'b0) begin
            errors++;
            $display("FAIL arst_flags got rw %0h ld %0h want 0 0", ex_reg_write, ex_is_load);
        end
        #4;
        #2;
        rst_n = 1'b1;
        step();
        checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'h0) begin errors++; $display("FAIL arst_after got valid %0h pc %0h want 0 0", ex_valid, ex_pc); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_operand_select();
        test_forward_priority();
        test_load_use();
        test_back_pressure();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX boundary register and operand-selection stage that directly feeds the execute ALU (alu_i0, alu_i1, alu_s).
- Latches decoded instructions from decode and applies MEM/WB forwarding to the latched register operands.
- Detects load-use hazards, inserts bubbles and supports pipeline flush.
- Uses a valid/ready handshake on both sides, so execute back-pressure stalls decode.

Parameters:
WIDTH, 32, datapath width
RADDR_W, 5, register-file address width
OP_W, 4, ALU select width

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous, active-low reset
id_valid  in  1  decode presents an instruction
id_ready  out  1  stage accepts the decode instruction this cycle
id_pc  in  WIDTH  instruction PC
id_rs1_data  in  WIDTH  register-file read data for rs1
id_rs2_data  in  WIDTH  register-file read data for rs2
id_imm  in  WIDTH  sign-extended immediate
id_rs1_addr  in  RADDR_W  rs1 index
id_rs2_addr  in  RADDR_W  rs2 index
id_rd_addr  in  RADDR_W  destination index
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_src_a_sel  in  2  operand A source: 0 = rs1, 1 = pc, 2 = zero, 3 = reserved (treated as zero)
id_src_b_sel  in  1  operand B source: 0 = rs2, 1 = imm
id_alu_op  in  OP_W  ALU select, passed through unmodified
id_reg_write  in  1  writes rd
id_is_load  in  1  load instruction
flush  in  1  kill the instruction held in EX and the one offered by decode
mem_fwd_valid  in  1  MEM stage holds a final result for mem_fwd_rd (low for loads still in flight)
mem_fwd_rd  in  RADDR_W  MEM destination
mem_fwd_data  in  WIDTH  MEM result
wb_fwd_valid  in  1  WB stage writes wb_fwd_rd this cycle
wb_fwd_rd  in  RADDR_W  WB destination
wb_fwd_data  in  WIDTH  WB result
ex_ready  in  1  execute/MEM consumes the EX instruction this cycle
ex_valid  out  1  EX register holds a live instruction
alu_i0  out  WIDTH  ALU operand A
alu_i1  out  WIDTH  ALU operand B
alu_s  out  OP_W  ALU select
ex_pc  out  WIDTH  latched PC
ex_store_data  out  WIDTH  forwarded rs2 value, for stores
ex_rd  out  RADDR_W  latched destination index
ex_reg_write  out  1  latched write-enable, gated by ex_valid
ex_is_load  out  1  latched load flag, gated by ex_valid

Behaviour:
- Reset (async, rst_n = 0):
  - All EX registers clear to 0; ex_valid = 0.
  - All outputs read 0 during and after reset until the first capture.
  - Reset mid-stall discards the held instruction.
- Hazard definition: hazard = ex_valid & ex_is_load_q & (ex_rd_q != 0) & ((id_use_rs1 & id_rs1_addr == ex_rd_q) | (id_use_rs2 & id_rs2_addr == ex_rd_q)).
- id_ready = (~ex_valid | ex_ready) & ~hazard & ~flush.
- Register update, each rising edge, in priority order:
  1. flush: ex_valid <= 0; decode's offer is not accepted.
  2. id_valid & id_ready: capture all id_* fields; ex_valid <= 1.
  3. ex_ready (or ~ex_valid) without capture: ex_valid <= 0. This is the bubble; the hazard case lands here.
  4. Otherwise: hold all fields (downstream stall).
- Latency: one cycle from accept to ex_valid.
- Load-use: exactly one bubble. The dependent instruction enters EX when the load reaches WB and takes its value via the WB forward.
- Forwarding (combinational, per source rs1/rs2, using the latched index):
  - Index 0 always yields 0.
  - Else if mem_fwd_valid and mem_fwd_rd matches: mem_fwd_data.
  - Else if wb_fwd_valid and wb_fwd_rd matches: wb_fwd_data.
  - Else the latched register data.
  - MEM has priority over WB when both match.
- Operand selection:
  - alu_i0 = forwarded rs1, ex_pc, or 0 per src_a_sel.
  - alu_i1 = forwarded rs2 or imm per src_b_sel.
  - ex_store_data = forwarded rs2, always.
- alu_s = latched alu_op, unmodified.
- Invalid EX: when ex_valid = 0, ex_reg_write and ex_is_load read 0. Datapath outputs are don't-care but must not be X after reset.
- flush and hazard in the same cycle: flush wins.
- flush while downstream is stalled (ex_ready = 0): the EX instruction is still killed.

Decomposition:
- Package ex_pkg holds:
  - SRC_A_RS1, SRC_A_PC, SRC_A_ZERO and SRC_B_RS2, SRC_B_IMM constants.
  - A packed id_ex_t struct holding all latched fields.
  - The ALU select encodings shared with decode.
- One sub-module, fwd_mux: combinational forward selection for one operand (index, reg data, MEM/WB inputs → value), instantiated twice.

Test Plan:
- Basic pass-through: reset, then accept add with rs1 = x1 (0x10), rs2 = x2 (0x20), no forwards → next cycle ex_valid = 1, alu_i0 = 0x10, alu_i1 = 0x20, alu_s = id_alu_op.
- Forward priority: EX holds rs1 = x5 with reg data 0x1; mem_fwd x5 = 0xAA and wb_fwd x5 = 0xBB both valid → alu_i0 = 0xAA. Drop MEM → 0xBB. rs1 = x0 with both forwarding x0 → alu_i0 = 0.
- Load-use: lw x3 in EX, decode offers add using rs2 = x3 →
  - id_ready = 0 for one cycle and the next EX is a bubble (ex_valid = 0).
  - The add enters the cycle after; with wb_fwd x3 = 0x1234, alu_i1 = 0x1234.
- Back-pressure: ex_valid = 1 and ex_ready held 0 for 3 cycles → id_ready = 0 and all outputs stable. Release → new instruction captured next edge.
- Flush: flush = 1 while ex_valid = 1, id_valid = 1, ex_ready = 0 → next cycle ex_valid = 0, offer not accepted, ex_reg_write = 0.
- Async reset: assert rst_n = 0 mid-cycle while stalled → ex_valid and all outputs 0 immediately, without waiting for clk.
